// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one 8N1 UART transmit line among NUM_REQ byte sources
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_arb #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int NUM_REQ   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       txd
);

  localparam int BIT_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW      = $clog2(BIT_DIV);
  localparam int OW      = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         idx_q;
  logic [7:0]         byte_q;
  logic [OW-1:0]      last_q, owner_q, sel_d;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q, txd_q;
  logic               found, bit_end;
  int                 scan;

  // Scan from the requester after the last grant, wrapping, so every source waits at most NUM_REQ-1 frames.
  always_comb begin
    sel_d = last_q;
    found = 1'b0;
    scan  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan = (int'(last_q) + i) % NUM_REQ;
      if (!found && req[OW'(scan)]) begin
        found = 1'b1;
        sel_d = OW'(scan);
      end
    end
  end

  always_comb begin
    bit_end = (cnt_q == CW'(BIT_DIV - 1));
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      grant_q <= '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            byte_q  <= data[{sel_d, 3'b000} +: 8];
            owner_q <= sel_d;
            last_q  <= sel_d;
            grant_q <= NUM_REQ'(1) << sel_d;
            busy_q  <= 1'b1;
            txd_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            txd_q   <= byte_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd_q   <= ^byte_q;
              state_q <= PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
              txd_q <= byte_q[idx_q + 3'd1];
            end
          end
        end
        PARITY: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            txd_q   <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          cnt_q <= cnt_d;
          // Returning through IDLE for one cycle gives the mandatory gap between frames.
          if (bit_end) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign txd   = txd_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed scoreboard bench for uart_tx_arb (honours UART_TX_PARITY_EN)
module tb_uart_tx_arb;

  localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk, rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy, txd;

  uart_tx_arb #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .NUM_REQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .grant(grant), .owner(owner), .busy(busy), .txd(txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_grants = 0;
  int cyc = 0;
  int exp_grant_q[$];
  logic [7:0] exp_byte_q[$];
  int starts_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant monitor: each grant pulse pops the next expected requester.
  always @(negedge clk) begin
    int e;
    if (!rst && grant !== 4'b0) begin
      n_grants++;
      if (exp_grant_q.size() == 0) chk("unexpected_grant", grant, 0);
      else begin
        e = exp_grant_q.pop_front();
        chk("grant", grant, 32'(1) << e);
        chk("owner", owner, e);
        chk("busy_at_grant", busy, 1);
      end
    end
  end

  // Line decoder: samples mid-bit, pops the expected byte at the stop bit.
  logic       in_frame = 1'b0;
  int         pos = 0;
  int         bcnt = 0;
  logic [7:0] rx;
  logic       rx_par;
  always @(negedge clk) begin
    logic [7:0] e;
    int k;
    cyc++;
    if (rst) begin
      in_frame = 1'b0;
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      else if (bcnt != 0) begin
        chk("busy_len", bcnt, NB * BD);
        bcnt = 0;
      end
      if (!in_frame && txd === 1'b0) begin
        in_frame = 1'b1;
        pos = 0;
        starts_q.push_back(cyc);
      end else if (in_frame) begin
        pos++;
      end
      if (in_frame && (pos % BD) == BD / 2) begin
        k = pos / BD;
        if (k == 0) chk("start_bit", txd, 0);
        else if (k <= 8) rx[k-1] = txd;
        else if (k == NB - 1) begin
          chk("stop_bit", txd, 1);
          if (exp_byte_q.size() == 0) chk("unexpected_frame", rx, 0);
          else begin
            e = exp_byte_q.pop_front();
            chk("byte", rx, e);
`ifdef UART_TX_PARITY_EN
            chk("parity", rx_par, ^e);
`endif
          end
        end else rx_par = txd;
      end
      if (in_frame && pos == NB * BD - 1) in_frame = 1'b0;
    end
  end

  task automatic wait_done(input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (exp_byte_q.size() == 0 && exp_grant_q.size() == 0 && !busy && !in_frame) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("timeout_done", 0, 1);
  endtask

  task automatic wait_grants(input int target, input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (n_grants >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("timeout_grant", n_grants, target);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; data = 32'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte from requester 2, request held one cycle
    req = 4'b0100; data[23:16] = 8'hA5;
    exp_grant_q.push_back(2); exp_byte_q.push_back(8'hA5);
    @(negedge clk);
    chk("single_grant_latency", grant, 4'b0100);
    req = 4'b0;
    wait_done(300);
    repeat (3) @(negedge clk);

    // All four held high from reset release
    rst = 1'b1; req = 4'hF; data = {8'h3C, 8'hC3, 8'h5A, 8'h81};
    @(negedge clk);
    starts_q.delete();
    foreach (exp_grant_q[i]) chk("queue_clean", 1, 0);
    for (int i = 0; i < 5; i++) begin
      exp_grant_q.push_back(i % 4);
      exp_byte_q.push_back(data[8*(i%4) +: 8]);
    end
    rst = 1'b0;
    wait_grants(n_grants + 5, 800);
    req = 4'b0;
    wait_done(300);
    chk("rr_starts", starts_q.size(), 5);
    for (int i = 1; i < 5 && i < starts_q.size(); i++)
      chk("rr_spacing", starts_q[i] - starts_q[i-1], NB * BD + 1);
    repeat (3) @(negedge clk);

    // Stale pointer: after 3, requesters 0 and 3 both pending -> 0 first
    req = 4'b1000; data = {8'hC3, 8'h00, 8'h00, 8'h3C};
    exp_grant_q.push_back(3); exp_byte_q.push_back(8'hC3);
    wait_grants(n_grants + 1, 20);
    req = 4'b1001;
    exp_grant_q.push_back(0); exp_byte_q.push_back(8'h3C);
    exp_grant_q.push_back(3); exp_byte_q.push_back(8'hC3);
    wait_grants(n_grants + 1, 300);
    req = 4'b1000;
    wait_grants(n_grants + 1, 300);
    req = 4'b0;
    wait_done(300);
    repeat (3) @(negedge clk);

    // req[1] pulses mid-frame only: ignored
    req = 4'b0001; data[7:0] = 8'h96;
    exp_grant_q.push_back(0); exp_byte_q.push_back(8'h96);
    wait_grants(n_grants + 1, 20);
    req = 4'b0;
    repeat (30) @(negedge clk);
    req = 4'b0010;
    repeat (20) @(negedge clk);
    req = 4'b0;
    wait_done(300);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("idle_txd", txd, 1);
      chk("idle_grant", grant, 0);
    end

    // Byte 0x07 (parity 1 when enabled)
    req = 4'b0010; data[15:8] = 8'h07;
    exp_grant_q.push_back(1); exp_byte_q.push_back(8'h07);
    wait_grants(n_grants + 1, 20);
    req = 4'b0;
    wait_done(300);
    repeat (3) @(negedge clk);

    // Reset during data bit 4, then a fresh frame from requester 0
    req = 4'b0100; data[23:16] = 8'h0F;
    exp_grant_q.push_back(2);
    wait_grants(n_grants + 1, 20);
    req = 4'b0;
    repeat (55) @(negedge clk);
    chk("bit4_level", txd, 0);
    rst = 1'b1;
    #1;
    chk("abort_txd", txd, 1);
    chk("abort_busy", busy, 0);
    chk("abort_grant", grant, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req = 4'b0001; data[7:0] = 8'h5A;
    exp_grant_q.push_back(0); exp_byte_q.push_back(8'h5A);
    @(negedge clk);
    chk("post_reset_grant", grant, 4'b0001);
    req = 4'b0;
    wait_done(300);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
